// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers per-digit BCD values from multiplexed active-low 7-segment scan lines
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   seg_err,
    output logic                    update,
    output logic [2:0]              update_idx,
    output logic                    timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [NUM_DIGITS-1:0] an_s1;
    logic [NUM_DIGITS-1:0] s_an;
    logic [6:0]            seg_s1;
    logic [6:0]            s_seg;
    logic [NUM_DIGITS+6:0] prev;
    logic [7:0]            cnt;
    logic [WD_W-1:0]       wd;

    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            nz;
    logic [2:0]            idx;
    logic                  legal_an;
    logic                  same;
    logic                  capture;
    logic [4:0]            dec;

    // {legal, value}; anything outside the ten digit glyphs is reported illegal
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        sel = ~s_an;
        nz  = 4'd0;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                nz  = nz + 4'd1;
                idx = 3'(i);
            end
        end
        legal_an = (nz == 4'd1);
        same     = ({s_an, s_seg} == prev);
        // Fires only on the transition into STABLE_CNT, so a held value captures once
        capture  = legal_an && same && (cnt == 8'(STABLE_CNT - 1));
        dec      = decode(s_seg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_s1       <= '0;
            s_an        <= '0;
            seg_s1      <= '0;
            s_seg       <= '0;
            prev        <= '0;
            cnt         <= '0;
            wd          <= '0;
            digits      <= '0;
            digit_valid <= '0;
            seg_err     <= '0;
            update      <= 1'b0;
            update_idx  <= '0;
            timeout     <= 1'b0;
        end else begin
            an_s1   <= an;
            s_an    <= an_s1;
            seg_s1  <= seg;
            s_seg   <= seg_s1;
            prev    <= {s_an, s_seg};
            update  <= capture;
            timeout <= 1'b0;

            if (!legal_an)
                cnt <= '0;
            else if (!same)
                cnt <= 8'd1;
            else if (cnt != 8'(STABLE_CNT))
                cnt <= cnt + 8'd1;

            if (capture) begin
                update_idx <= idx;
                wd         <= '0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        if (dec[4]) begin
                            digits[4*i +: 4] <= dec[3:0];
                            digit_valid[i]   <= 1'b1;
                            seg_err[i]       <= 1'b0;
                        end else begin
                            digit_valid[i]   <= 1'b0;
                            seg_err[i]       <= 1'b1;
                        end
                    end
                end
            end else if (wd == WD_W'(TIMEOUT - 1)) begin
                wd          <= '0;
                digit_valid <= '0;
                timeout     <= 1'b1;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  seg_err;
    logic        update;
    logic [2:0]  update_idx;
    logic        timeout;

    int comp;
    int fails;
    int upd_cnt;
    int to_cnt;
    logic [2:0] last_idx;

    seg7_scan_decoder #(
        .NUM_DIGITS(4),
        .STABLE_CNT(4),
        .TIMEOUT(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .an(an),
        .seg(seg),
        .digits(digits),
        .digit_valid(digit_valid),
        .seg_err(seg_err),
        .update(update),
        .update_idx(update_idx),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_guard: got no finish, exp finish before 200000ns");
        $fatal(1);
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (update) begin
                upd_cnt++;
                last_idx = update_idx;
            end
            if (timeout) to_cnt++;
        end
    endtask

    task automatic test_reset();
        logic early;
        rst = 1'b1; an = 4'b1110; seg = 7'b0010010;
        step(2);
        comp++;
        if ({digits, digit_valid, seg_err, update, update_idx, timeout} !== 31'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b/%0d/%b exp all zero",
                     digits, digit_valid, seg_err, update, update_idx, timeout);
        end
        rst = 1'b0;
        early = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            if (update) early = 1'b1;
        end
        comp++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL reset_latency_early: got update before edge 6, exp none");
        end
        step(1);
        comp++;
        if (update !== 1'b1 || update_idx !== 3'd0) begin
            fails++;
            $display("FAIL reset_first_update: got update=%b idx=%0d exp 1 idx=0", update, update_idx);
        end
        comp++;
        if (digits[3:0] !== 4'd2 || digit_valid !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_value: got d0=%0d valid=%b exp 2 0001", digits[3:0], digit_valid);
        end
        upd_cnt = 0;
        step(20);
        comp++;
        if (upd_cnt !== 0) begin
            fails++;
            $display("FAIL held_single_update: got %0d extra updates exp 0", upd_cnt);
        end
    endtask

    task automatic test_full_scan();
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b1001111, 7'b0000100, 7'b1001100, 7'b0001111};
        upd_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 4; d++) begin
                an = an_tab[d]; seg = seg_tab[d];
                step(20);
            end
        end
        comp++;
        if (upd_cnt !== 8) begin
            fails++;
            $display("FAIL scan_update_count: got %0d exp 8", upd_cnt);
        end
        comp++;
        if (digits !== 16'h7491) begin
            fails++;
            $display("FAIL scan_digits: got %h exp 7491", digits);
        end
        comp++;
        if (digit_valid !== 4'b1111 || seg_err !== 4'b0000) begin
            fails++;
            $display("FAIL scan_flags: got valid=%b err=%b exp 1111 0000", digit_valid, seg_err);
        end
    endtask

    task automatic test_glitch();
        upd_cnt = 0;
        an = 4'b1101; seg = 7'b1111111;
        step(3);
        seg = 7'b0000110;
        step(5);
        comp++;
        if (upd_cnt !== 0) begin
            fails++;
            $display("FAIL glitch_captured: got %0d updates exp 0", upd_cnt);
        end
        step(1);
        comp++;
        if (update !== 1'b1 || update_idx !== 3'd1 || digits[7:4] !== 4'd3) begin
            fails++;
            $display("FAIL glitch_recover: got update=%b idx=%0d d1=%0d exp 1 1 3",
                     update, update_idx, digits[7:4]);
        end
    endtask

    task automatic test_illegal();
        upd_cnt = 0;
        an = 4'b1011; seg = 7'b1111111;
        step(10);
        comp++;
        if (upd_cnt !== 1 || last_idx !== 3'd2) begin
            fails++;
            $display("FAIL illegal_update: got count=%0d idx=%0d exp 1 2", upd_cnt, last_idx);
        end
        comp++;
        if (seg_err !== 4'b0100 || digit_valid !== 4'b1011 || digits[11:8] !== 4'd4) begin
            fails++;
            $display("FAIL illegal_flags: got err=%b valid=%b d2=%0d exp 0100 1011 4",
                     seg_err, digit_valid, digits[11:8]);
        end
        seg = 7'b0100000;
        step(10);
        comp++;
        if (digits[11:8] !== 4'd6 || seg_err !== 4'b0000 || digit_valid !== 4'b1111) begin
            fails++;
            $display("FAIL illegal_recover: got d2=%0d err=%b valid=%b exp 6 0000 1111",
                     digits[11:8], seg_err, digit_valid);
        end
    endtask

    task automatic test_bad_anodes();
        upd_cnt = 0;
        to_cnt  = 0;
        an = 4'b1111; seg = 7'b0000000;
        step(25);
        an = 4'b1100; seg = 7'b1001111;
        step(25);
        comp++;
        if (upd_cnt !== 0 || to_cnt !== 0) begin
            fails++;
            $display("FAIL bad_anodes_update: got updates=%0d timeouts=%0d exp 0 0", upd_cnt, to_cnt);
        end
        comp++;
        if (digits !== 16'h7631 || digit_valid !== 4'b1111 || seg_err !== 4'b0000) begin
            fails++;
            $display("FAIL bad_anodes_state: got %h/%b/%b exp 7631/1111/0000",
                     digits, digit_valid, seg_err);
        end
    endtask

    task automatic test_watchdog();
        logic found;
        logic early;
        an = 4'b1110; seg = 7'b0100100;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (update) found = 1'b1;
        end
        comp++;
        if (found !== 1'b1) begin
            fails++;
            $display("FAIL wd_capture: got no update in 20 cycles exp update");
        end
        an = 4'b1111;
        early = 1'b0;
        for (int k = 1; k < 100; k++) begin
            step(1);
            if (timeout) early = 1'b1;
        end
        comp++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL wd_early: got timeout before 100 cycles exp none");
        end
        step(1);
        comp++;
        if (timeout !== 1'b1 || digit_valid !== 4'b0000) begin
            fails++;
            $display("FAIL wd_expire: got timeout=%b valid=%b exp 1 0000", timeout, digit_valid);
        end
        comp++;
        if (digits !== 16'h7635 || seg_err !== 4'b0000) begin
            fails++;
            $display("FAIL wd_keep: got digits=%h err=%b exp 7635 0000", digits, seg_err);
        end
        step(1);
        comp++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL wd_pulse_width: got timeout=%b exp 0", timeout);
        end
    endtask

    task automatic test_reset_midrun();
        logic early;
        an = 4'b1101; seg = 7'b0000000;
        step(3);
        rst = 1'b1;
        step(1);
        comp++;
        if ({digits, digit_valid, seg_err, update, timeout} !== 26'd0) begin
            fails++;
            $display("FAIL midrun_reset: got %h/%b/%b/%b/%b exp all zero",
                     digits, digit_valid, seg_err, update, timeout);
        end
        rst = 1'b0;
        early = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            if (update) early = 1'b1;
        end
        comp++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL midrun_early: got update before fresh run exp none");
        end
        step(1);
        comp++;
        if (update !== 1'b1 || update_idx !== 3'd1 || digits !== 16'h0080 || digit_valid !== 4'b0010) begin
            fails++;
            $display("FAIL midrun_capture: got update=%b idx=%0d digits=%h valid=%b exp 1 1 0080 0010",
                     update, update_idx, digits, digit_valid);
        end
    endtask

    initial begin
        comp = 0; fails = 0; upd_cnt = 0; to_cnt = 0; last_idx = 3'd0;
        rst = 1'b1; an = 4'b1111; seg = 7'b1111111;
        test_reset();
        test_full_scan();
        test_glitch();
        test_illegal();
        test_bad_anodes();
        test_watchdog();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, fails);
        $finish;
    end

endmodule
